cordic_rr_scheduler: RTL

Round-robin scheduler that shares one CORDIC sin/cos core between NUM_REQ independent requesters. Each requester hands over an IEEE754 single-precision angle and gets back Q15 sin/cos. The block sequences the core through start, wait and result, and adds a completion timeout. It sits between the requester logic (AXI-Lite register front-ends, DMA or test masters) and the single CORDIC instance.

---
 rtl/cordic_rr_scheduler.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cordic_rr_scheduler.sv
// ============================================================================
// cordic_rr_scheduler
//
// Shares a single CORDIC sin/cos core between NUM_REQ requesters. Each
// requester hands over an IEEE754 single-precision angle; the scheduler
// forwards it bit-exact to the core, waits for the result (with a completion
// timeout) and returns Q15 sin/cos on a shared response bus to the requester
// that owns the job.
//
// Arbitration is round-robin: the search for the next grant starts one past
// the requester whose response most recently completed. The pointer moves
// only on response completion, so a requester holding req_valid waits at most
// NUM_REQ-1 jobs.
//
// Handshake semantics (both channels, per requester i):
//   A transfer happens on a rising clk edge where valid[i] and ready[i] are
//   both high. A requester keeps req_valid[i] and its angle stable until the
//   transfer; the scheduler keeps rsp_valid[i] and rsp_sin/rsp_cos/rsp_err
//   stable until rsp_ready[i] is seen. ready may depend combinationally on
//   valid, never the other way round.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_valid/ready   per-requester job handshake (ready is one-hot)
//   req_angle         packed angles, requester i at [32*i+31:32*i]
//   rsp_valid/ready   per-requester result handshake (valid is one-hot)
//   rsp_sin/cos/err   shared result bus; err=1 means timeout, sin=cos=0
//   busy              high whenever the FSM is not IDLE
//   grant_id          requester currently owning (or last owning) the core
//   core_start        one-cycle start pulse to the CORDIC
//   core_angle        angle to the CORDIC, stable for the whole job
//   core_done         one-cycle completion pulse from the CORDIC
//   core_sin/cos      CORDIC results, valid with core_done
//   dbg_state         current FSM state (IDLE=0, START=1, WAIT=2, RESP=3)
// ============================================================================
module cordic_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*32-1:0]      req_angle,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [15:0]                rsp_sin,
    output logic [15:0]                rsp_cos,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       core_start,
    output logic [31:0]                core_angle,
    input  logic                       core_done,
    input  logic [15:0]                core_sin,
    input  logic [15:0]                core_cos,
    output logic [1:0]                 dbg_state
);

    localparam int GW = $clog2(NUM_REQ);
    // The counter only ever reaches TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [GW-1:0]   last;       // requester whose response completed last
    logic [CW-1:0]   cnt;        // WAIT cycle counter for the timeout

    // Combinational arbitration results
    logic            arb_found;
    logic [GW-1:0]   arb_idx;
    logic [GW-1:0]   cand;
    logic [31:0]     sel_angle;

    // FSM decode strobes
    logic            accept;
    logic            wait_done;
    logic            wait_to;
    logic            rsp_fire;

    // ------------------------------------------------------------------
    // Round-robin search: offsets 1..NUM_REQ from last, so the requester
    // that was just served is considered last.
    // ------------------------------------------------------------------
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last) + k) % NUM_REQ);
            if (!arb_found && req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Angle of the winning requester, selected with constant part-selects.
    always_comb begin
        sel_angle = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == arb_idx) begin
                sel_angle = req_angle[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        wait_done = 1'b0;
        wait_to   = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            S_IDLE: begin
                // core_done is deliberately not looked at here: a result from
                // a job killed by reset must not surface.
                if (arb_found) begin
                    req_ready[arb_idx] = 1'b1;
                    accept             = 1'b1;
                    state_n            = S_START;
                end
            end
            S_START: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // Done has priority over a coincident timeout.
                if (core_done) begin
                    wait_done = 1'b1;
                    state_n   = S_RESP;
                end else if (cnt == TO_LAST) begin
                    wait_to = 1'b1;
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[grant_id] = 1'b1;
                if (rsp_ready[grant_id]) begin
                    rsp_fire = 1'b1;
                    state_n  = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign core_start = (state == S_START);
    assign busy       = (state != S_IDLE);
    assign dbg_state  = state;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last       <= GW'(NUM_REQ - 1);
            grant_id   <= '0;
            core_angle <= '0;
            cnt        <= '0;
            rsp_sin    <= '0;
            rsp_cos    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_n;

            if (accept) begin
                grant_id   <= arb_idx;
                core_angle <= sel_angle;
            end

            if (state == S_START) begin
                cnt <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CW'(1);
            end

            if (wait_done) begin
                rsp_sin <= core_sin;
                rsp_cos <= core_cos;
                rsp_err <= 1'b0;
            end else if (wait_to) begin
                rsp_sin <= '0;
                rsp_cos <= '0;
                rsp_err <= 1'b1;
            end

            // Fairness pointer moves only when a response is consumed.
            if (rsp_fire) begin
                last <= grant_id;
            end
        end
    end

endmodule
